vx_mem_responder: RTL and testbench

VX_MEM_RESPONDER -- requirements
Module: vx_mem_responder

---
 rtl/vx_mem_responder.sv | 166 ++++++++++++++++
 tb/tb_vx_mem_responder.sv | 326 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vx_mem_responder.sv
// Latency-modelled line memory with ordered, credit-limited read responses.
// Define VX_MEM_RESPONDER_STATS_EN to add perf_reads/perf_writes/perf_stalls.
module vx_mem_responder #(
  parameter int DATA_WIDTH     = 512,
  parameter int ADDR_WIDTH     = 26,
  parameter int TAG_WIDTH      = 8,
  parameter int MEM_WORDS      = 1024,
  parameter int LATENCY        = 4,
  parameter int RSP_QUEUE_SIZE = 8
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    mem_req_valid,
  input  logic                    mem_req_rw,
  input  logic [DATA_WIDTH/8-1:0] mem_req_byteen,
  input  logic [ADDR_WIDTH-1:0]   mem_req_addr,
  input  logic [DATA_WIDTH-1:0]   mem_req_data,
  input  logic [TAG_WIDTH-1:0]    mem_req_tag,
  output logic                    mem_req_ready,
  output logic                    mem_rsp_valid,
  output logic [DATA_WIDTH-1:0]   mem_rsp_data,
  output logic [TAG_WIDTH-1:0]    mem_rsp_tag,
  input  logic                    mem_rsp_ready,
  output logic                    busy
`ifdef VX_MEM_RESPONDER_STATS_EN
  ,
  output logic [31:0]             perf_reads,
  output logic [31:0]             perf_writes,
  output logic [31:0]             perf_stalls
`endif
);

  localparam int AW = $clog2(MEM_WORDS);
  localparam int QW = $clog2(RSP_QUEUE_SIZE);
  localparam int BW = DATA_WIDTH / 8;
  localparam int P  = LATENCY - 1;
  localparam logic [QW:0] QFULL = (QW+1)'(RSP_QUEUE_SIZE);

  logic [DATA_WIDTH-1:0] r_mem [MEM_WORDS];

  logic [AW-1:0]            w_idx;
  logic [ADDR_WIDTH-AW-1:0] w_unused_hi;
  logic                     w_rd_fire;
  logic                     w_wr_fire;
  logic                     w_rsp_fire;
  logic                     w_push_v;
  logic [DATA_WIDTH-1:0]    w_push_d;
  logic [TAG_WIDTH-1:0]     w_push_t;

  logic [QW:0]           r_outstanding;
  logic [QW:0]           r_wptr;
  logic [QW:0]           r_rptr;
  logic [DATA_WIDTH-1:0] r_fd [RSP_QUEUE_SIZE];
  logic [TAG_WIDTH-1:0]  r_ft [RSP_QUEUE_SIZE];

  assign w_idx       = mem_req_addr[AW-1:0];
  assign w_unused_hi = mem_req_addr[ADDR_WIDTH-1:AW];
  assign w_rd_fire   = mem_req_valid && mem_req_ready && !mem_req_rw;
  assign w_wr_fire   = mem_req_valid && mem_req_ready && mem_req_rw;
  assign w_rsp_fire  = mem_rsp_valid && mem_rsp_ready;

  assign mem_req_ready = (r_outstanding != QFULL);
  assign busy          = (r_outstanding != '0);

  always_ff @(posedge clk) begin
    if (w_wr_fire) begin
      for (int b = 0; b < BW; b++) begin
        if (mem_req_byteen[b])
          r_mem[w_idx][b*8 +: 8] <= mem_req_data[b*8 +: 8];
      end
    end
  end

  // Capture stage plus LATENCY-1 registers; the FIFO write is the last stage.
  if (LATENCY == 1) begin : g_direct
    assign w_push_v = w_rd_fire;
    assign w_push_d = r_mem[w_idx];
    assign w_push_t = mem_req_tag;
  end else begin : g_pipe
    logic [P-1:0]          r_pv;
    logic [DATA_WIDTH-1:0] r_pd [P];
    logic [TAG_WIDTH-1:0]  r_pt [P];

    always_ff @(posedge clk) begin
      if (reset) begin
        r_pv <= '0;
      end else begin
        r_pv[0] <= w_rd_fire;
        for (int i = 1; i < P; i++)
          r_pv[i] <= r_pv[i-1];
      end
    end

    always_ff @(posedge clk) begin
      r_pd[0] <= r_mem[w_idx];
      r_pt[0] <= mem_req_tag;
      for (int i = 1; i < P; i++) begin
        r_pd[i] <= r_pd[i-1];
        r_pt[i] <= r_pt[i-1];
      end
    end

    assign w_push_v = r_pv[P-1];
    assign w_push_d = r_pd[P-1];
    assign w_push_t = r_pt[P-1];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (w_push_v)
        r_wptr <= r_wptr + 1'b1;
      if (w_rsp_fire)
        r_rptr <= r_rptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_push_v) begin
      r_fd[r_wptr[QW-1:0]] <= w_push_d;
      r_ft[r_wptr[QW-1:0]] <= w_push_t;
    end
  end

  assign mem_rsp_valid = (r_wptr != r_rptr);
  assign mem_rsp_data  = r_fd[r_rptr[QW-1:0]];
  assign mem_rsp_tag   = r_ft[r_rptr[QW-1:0]];

  always_ff @(posedge clk) begin
    if (reset) begin
      r_outstanding <= '0;
    end else if (w_rd_fire && !w_rsp_fire) begin
      r_outstanding <= r_outstanding + 1'b1;
    end else if (!w_rd_fire && w_rsp_fire) begin
      r_outstanding <= r_outstanding - 1'b1;
    end
  end

`ifdef VX_MEM_RESPONDER_STATS_EN
  logic [31:0] r_perf_reads;
  logic [31:0] r_perf_writes;
  logic [31:0] r_perf_stalls;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_perf_reads  <= '0;
      r_perf_writes <= '0;
      r_perf_stalls <= '0;
    end else begin
      if (w_rd_fire)
        r_perf_reads <= r_perf_reads + 32'd1;
      if (w_wr_fire)
        r_perf_writes <= r_perf_writes + 32'd1;
      if (mem_req_valid && !mem_req_ready)
        r_perf_stalls <= r_perf_stalls + 32'd1;
    end
  end

  assign perf_reads  = r_perf_reads;
  assign perf_writes = r_perf_writes;
  assign perf_stalls = r_perf_stalls;
`endif

endmodule

// File: tb/tb_vx_mem_responder.sv
// Directed bench for vx_mem_responder: latency, byte enables, credits, reset.
// Stats checks are compiled in when VX_MEM_RESPONDER_STATS_EN is defined.
module tb_vx_mem_responder;

  localparam int DW = 64;
  localparam int AW = 26;
  localparam int TW = 8;
  localparam int L  = 4;
  localparam int Q  = 8;

  logic          clk;
  logic          reset;
  logic          mem_req_valid;
  logic          mem_req_rw;
  logic [DW/8-1:0] mem_req_byteen;
  logic [AW-1:0] mem_req_addr;
  logic [DW-1:0] mem_req_data;
  logic [TW-1:0] mem_req_tag;
  logic          mem_req_ready;
  logic          mem_rsp_valid;
  logic [DW-1:0] mem_rsp_data;
  logic [TW-1:0] mem_rsp_tag;
  logic          mem_rsp_ready;
  logic          busy;
`ifdef VX_MEM_RESPONDER_STATS_EN
  logic [31:0]   perf_reads;
  logic [31:0]   perf_writes;
  logic [31:0]   perf_stalls;
`endif

  int n_pass  = 0;
  int n_total = 0;

  vx_mem_responder #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .TAG_WIDTH(TW),
    .MEM_WORDS(16), .LATENCY(L), .RSP_QUEUE_SIZE(Q)
  ) dut (
    .clk(clk), .reset(reset),
    .mem_req_valid(mem_req_valid), .mem_req_rw(mem_req_rw),
    .mem_req_byteen(mem_req_byteen), .mem_req_addr(mem_req_addr),
    .mem_req_data(mem_req_data), .mem_req_tag(mem_req_tag),
    .mem_req_ready(mem_req_ready),
    .mem_rsp_valid(mem_rsp_valid), .mem_rsp_data(mem_rsp_data),
    .mem_rsp_tag(mem_rsp_tag), .mem_rsp_ready(mem_rsp_ready),
    .busy(busy)
`ifdef VX_MEM_RESPONDER_STATS_EN
    , .perf_reads(perf_reads), .perf_writes(perf_writes),
    .perf_stalls(perf_stalls)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drive_rd(input logic [AW-1:0] a, input logic [TW-1:0] t);
    mem_req_valid = 1'b1;
    mem_req_rw    = 1'b0;
    mem_req_addr  = a;
    mem_req_tag   = t;
  endtask

  task automatic drive_wr(input logic [AW-1:0] a, input logic [DW-1:0] d,
                          input logic [DW/8-1:0] be);
    mem_req_valid  = 1'b1;
    mem_req_rw     = 1'b1;
    mem_req_addr   = a;
    mem_req_data   = d;
    mem_req_byteen = be;
  endtask

  task automatic test_reset;
    mem_req_valid = 1'b0; mem_req_rw = 1'b0; mem_req_byteen = '0;
    mem_req_addr = '0; mem_req_data = '0; mem_req_tag = '0;
    mem_rsp_ready = 1'b0;
    reset = 1'b1;
    tick; tick;
    reset = 1'b0;
    n_total++;
    if (mem_req_ready !== 1'b1) $display("FAIL rst_ready got %b want 1", mem_req_ready);
    else n_pass++;
    n_total++;
    if (mem_rsp_valid !== 1'b0) $display("FAIL rst_valid got %b want 0", mem_rsp_valid);
    else n_pass++;
    n_total++;
    if (busy !== 1'b0) $display("FAIL rst_busy got %b want 0", busy);
    else n_pass++;
  endtask

  task automatic test_write_read;
    drive_wr(26'h5, {8{8'hAA}}, 8'hFF);
    n_total++;
    if (mem_req_ready !== 1'b1) $display("FAIL wr_ready got %b want 1", mem_req_ready);
    else n_pass++;
    tick;
    drive_rd(26'h5, 8'h03);
    tick;
    mem_req_valid = 1'b0;
    for (int k = 1; k < L; k++) begin
      n_total++;
      if (mem_rsp_valid !== 1'b0) $display("FAIL lat_early k=%0d got %b want 0", k, mem_rsp_valid);
      else n_pass++;
      tick;
    end
    n_total++;
    if (mem_rsp_valid !== 1'b1) $display("FAIL lat_exact got %b want 1", mem_rsp_valid);
    else n_pass++;
    n_total++;
    if (mem_rsp_tag !== 8'h03) $display("FAIL rd_tag got %h want 03", mem_rsp_tag);
    else n_pass++;
    n_total++;
    if (mem_rsp_data !== 64'hAAAAAAAAAAAAAAAA) $display("FAIL rd_data got %h want aaaaaaaaaaaaaaaa", mem_rsp_data);
    else n_pass++;
    n_total++;
    if (busy !== 1'b1) $display("FAIL rd_busy got %b want 1", busy);
    else n_pass++;
    mem_rsp_ready = 1'b1;
    tick;
    mem_rsp_ready = 1'b0;
    n_total++;
    if (mem_rsp_valid !== 1'b0 || busy !== 1'b0)
      $display("FAIL rd_drain got valid=%b busy=%b want 0 0", mem_rsp_valid, busy);
    else n_pass++;
  endtask

  task automatic test_byteen;
    int w;
    drive_wr(26'h5, 64'h1234567890ABCD11, 8'h01);
    tick;
    drive_rd(26'h5, 8'h07);
    tick;
    mem_req_valid = 1'b0;
    w = 0;
    while (!mem_rsp_valid && w < 20) begin tick; w++; end
    n_total++;
    if (mem_rsp_valid !== 1'b1) $display("FAIL be_valid got %b want 1", mem_rsp_valid);
    else n_pass++;
    n_total++;
    if (mem_rsp_data !== 64'hAAAAAAAAAAAAAA11) $display("FAIL be_data got %h want aaaaaaaaaaaaaa11", mem_rsp_data);
    else n_pass++;
    n_total++;
    if (mem_rsp_tag !== 8'h07) $display("FAIL be_tag got %h want 07", mem_rsp_tag);
    else n_pass++;
    mem_rsp_ready = 1'b1;
    tick;
    mem_rsp_ready = 1'b0;
  endtask

  task automatic test_backpressure;
    mem_rsp_ready = 1'b0;
    for (int i = 0; i < Q; i++) begin
      drive_rd(AW'(i), TW'(i));
      n_total++;
      if (mem_req_ready !== 1'b1) $display("FAIL bp_fill_ready i=%0d got %b want 1", i, mem_req_ready);
      else n_pass++;
      tick;
    end
    mem_req_valid = 1'b0;
    n_total++;
    if (mem_req_ready !== 1'b0) $display("FAIL bp_full_ready got %b want 0", mem_req_ready);
    else n_pass++;
    n_total++;
    if (busy !== 1'b1) $display("FAIL bp_busy got %b want 1", busy);
    else n_pass++;
    repeat (L + 1) tick;
    mem_rsp_ready = 1'b1;
    n_total++;
    if (mem_req_ready !== 1'b0) $display("FAIL bp_ready_hold got %b want 0", mem_req_ready);
    else n_pass++;
    n_total++;
    if (mem_rsp_valid !== 1'b1 || mem_rsp_tag !== 8'h00)
      $display("FAIL bp_tag0 got v=%b tag=%h want 1 00", mem_rsp_valid, mem_rsp_tag);
    else n_pass++;
    tick;
    n_total++;
    if (mem_req_ready !== 1'b1) $display("FAIL bp_ready_reassert got %b want 1", mem_req_ready);
    else n_pass++;
    for (int i = 1; i < Q; i++) begin
      n_total++;
      if (mem_rsp_valid !== 1'b1 || mem_rsp_tag !== TW'(i))
        $display("FAIL bp_order i=%0d got v=%b tag=%h want 1 %h", i, mem_rsp_valid, mem_rsp_tag, TW'(i));
      else n_pass++;
      tick;
    end
    mem_rsp_ready = 1'b0;
    n_total++;
    if (busy !== 1'b0 || mem_rsp_valid !== 1'b0)
      $display("FAIL bp_done got busy=%b v=%b want 0 0", busy, mem_rsp_valid);
    else n_pass++;
  endtask

  task automatic test_back_to_back;
    logic [TW-1:0] exp_tag;
    int w;
    mem_rsp_ready = 1'b0;
    for (int i = 0; i < Q; i++) begin
      drive_rd(26'h5, 8'h10 + TW'(i));
      tick;
    end
    mem_req_valid = 1'b0;
    repeat (L + 1) tick;
    drive_rd(26'h5, 8'h20);
    mem_rsp_ready = 1'b1;
    n_total++;
    if (mem_req_ready !== 1'b0 || mem_rsp_tag !== 8'h10)
      $display("FAIL b2b_start got rdy=%b tag=%h want 0 10", mem_req_ready, mem_rsp_tag);
    else n_pass++;
    tick;
    for (int j = 1; j <= Q; j++) begin
      drive_rd(26'h5, 8'h20 + TW'(j - 1));
      exp_tag = (j < Q) ? 8'h10 + TW'(j) : 8'h20;
      n_total++;
      if (mem_req_ready !== 1'b1 || mem_rsp_valid !== 1'b1 || mem_rsp_tag !== exp_tag)
        $display("FAIL b2b_sim j=%0d got rdy=%b v=%b tag=%h want 1 1 %h",
                 j, mem_req_ready, mem_rsp_valid, mem_rsp_tag, exp_tag);
      else n_pass++;
      tick;
    end
    mem_req_valid = 1'b0;
    for (int k = 1; k < Q; k++) begin
      w = 0;
      while (!mem_rsp_valid && w < 20) begin tick; w++; end
      exp_tag = 8'h20 + TW'(k);
      n_total++;
      if (mem_rsp_valid !== 1'b1 || mem_rsp_tag !== exp_tag)
        $display("FAIL b2b_drain k=%0d got v=%b tag=%h want 1 %h", k, mem_rsp_valid, mem_rsp_tag, exp_tag);
      else n_pass++;
      tick;
    end
    mem_rsp_ready = 1'b0;
    n_total++;
    if (busy !== 1'b0 || mem_rsp_valid !== 1'b0)
      $display("FAIL b2b_done got busy=%b v=%b want 0 0", busy, mem_rsp_valid);
    else n_pass++;
  endtask

  task automatic test_reset_midflight;
    int stale;
    int w;
    mem_rsp_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive_rd(26'h5, 8'h30 + TW'(i));
      tick;
    end
    mem_req_valid = 1'b0;
    reset = 1'b1;
    tick;
    reset = 1'b0;
    n_total++;
    if (mem_rsp_valid !== 1'b0 || busy !== 1'b0 || mem_req_ready !== 1'b1)
      $display("FAIL mid_rst got v=%b busy=%b rdy=%b want 0 0 1", mem_rsp_valid, busy, mem_req_ready);
    else n_pass++;
    stale = 0;
    repeat (2 * L) begin
      if (mem_rsp_valid) stale++;
      tick;
    end
    n_total++;
    if (stale !== 0) $display("FAIL mid_stale got %0d want 0", stale);
    else n_pass++;
    drive_rd(26'h5, 8'h40);
    tick;
    mem_req_valid = 1'b0;
    w = 0;
    while (!mem_rsp_valid && w < 20) begin tick; w++; end
    n_total++;
    if (mem_rsp_valid !== 1'b1 || mem_rsp_tag !== 8'h40 || mem_rsp_data !== 64'hAAAAAAAAAAAAAA11)
      $display("FAIL mid_keep got v=%b tag=%h data=%h want 1 40 aaaaaaaaaaaaaa11",
               mem_rsp_valid, mem_rsp_tag, mem_rsp_data);
    else n_pass++;
    mem_rsp_ready = 1'b1;
    tick;
    mem_rsp_ready = 1'b0;
  endtask

`ifdef VX_MEM_RESPONDER_STATS_EN
  task automatic test_stats;
    mem_req_valid = 1'b0;
    mem_rsp_ready = 1'b0;
    reset = 1'b1;
    tick;
    reset = 1'b0;
    drive_wr(26'h1, {8{8'h55}}, 8'hFF);
    tick;
    drive_wr(26'h2, {8{8'h66}}, 8'hFF);
    tick;
    for (int i = 0; i < Q; i++) begin
      drive_rd(26'h1, TW'(i));
      tick;
    end
    repeat (3) tick;
    mem_req_valid = 1'b0;
    n_total++;
    if (perf_reads !== 32'd8) $display("FAIL perf_reads got %0d want 8", perf_reads);
    else n_pass++;
    n_total++;
    if (perf_writes !== 32'd2) $display("FAIL perf_writes got %0d want 2", perf_writes);
    else n_pass++;
    n_total++;
    if (perf_stalls !== 32'd3) $display("FAIL perf_stalls got %0d want 3", perf_stalls);
    else n_pass++;
    mem_rsp_ready = 1'b1;
    repeat (L + Q + 4) tick;
    mem_rsp_ready = 1'b0;
  endtask
`endif

  initial begin
    test_reset;
    test_write_read;
    test_byteen;
    test_backpressure;
    test_back_to_back;
    test_reset_midflight;
`ifdef VX_MEM_RESPONDER_STATS_EN
    test_stats;
`endif
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
